// File: rtl/hop_pkg.sv
// Shared definitions for the hop lane stimulus/checker: lane count, default
// timing, LFSR taps and the checker FSM state encoding.
package hop_pkg;

  localparam int LANES       = 4;
  localparam int EXP_LAT_DEF = 7;
  localparam int TIMEOUT_DEF = 31;

  // Taps 8,6,5,4 of the Fibonacci polynomial, mapped onto bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_e;

  // An all-zero pattern would launch nothing, so it becomes all lanes.
  function automatic logic [LANES-1:0] lane_pattern(input logic [7:0] s);
    return (s[3:0] == 4'h0) ? 4'hF : s[3:0];
  endfunction

endpackage

// File: rtl/hop_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that shifts left once per enabled cycle
// and reloads SEED on reset.
module hop_lfsr8
  import hop_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock0,
  input  logic       rst1,
  input  logic       en,
  output logic [7:0] state
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/hop_lane_stim_chk.sv
// Drives single-cycle pseudo-random patterns into the four hop lanes, times
// each lane's arrival and accumulates sticky per-lane errors over a run.
module hop_lane_stim_chk
  import hop_pkg::*;
#(
  parameter int         EXP_LAT   = EXP_LAT_DEF,
  parameter int         TIMEOUT   = TIMEOUT_DEF,
  parameter int         GAP_CYC   = 4,
  parameter int         NUM_ITER  = 16,
  parameter int         LAT_W     = 5,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                   clock0,
  input  logic                   rst1,
  input  logic                   run,
  input  logic [3:0]             lane_i,
  output logic [3:0]             start_o,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [3:0]             err_lane,
  output logic [4*LAT_W-1:0]     lat_last
);

  localparam int ITER_W = $clog2(NUM_ITER + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);

  // Run handshake: run is a level request sampled only in IDLE; done (with
  // pass) is held until run is seen low, after which the block returns to IDLE.
  state_e                 state_q, state_d;
  logic [3:0]             start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [3:0]             err_lane_q, err_lane_d;
  logic [4*LAT_W-1:0]     lat_last_q, lat_last_d;
  logic [3:0]             launched_q, launched_d;
  logic [3:0]             arrived_q, arrived_d;
  logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
  logic [ITER_W-1:0]      iter_q, iter_d;
  logic [GAP_W-1:0]       gap_q, gap_d;

  logic [7:0]             lfsr_state;
  logic                   lfsr_en;
  logic [3:0]             pattern;
  logic                   lat_ok;

  hop_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock0 (clock0),
    .rst1   (rst1),
    .en     (lfsr_en),
    .state  (lfsr_state)
  );

  assign pattern = lane_pattern(lfsr_state);

  always_comb begin
    state_d    = state_q;
    start_d    = '0;
    err_lane_d = err_lane_q;
    lat_last_d = lat_last_q;
    launched_d = launched_q;
    arrived_d  = arrived_q;
    lat_cnt_d  = lat_cnt_q;
    iter_d     = iter_q;
    gap_d      = gap_q;
    lfsr_en    = 1'b0;
    lat_ok     = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d    = LAUNCH;
          err_lane_d = '0;
          iter_d     = '0;
        end
      end

      LAUNCH: begin
        start_d    = pattern;
        launched_d = pattern;
        arrived_d  = '0;
        lat_cnt_d  = '0;
        lfsr_en    = 1'b1;
        state_d    = WAIT;
      end

      WAIT: begin
        if (lat_cnt_q != LAT_W'(TIMEOUT)) begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
        // Only the first high cycle of a lane is timed; longer pulses are benign.
        for (int i = 0; i < LANES; i++) begin
          if (lane_i[i] && !arrived_q[i]) begin
            arrived_d[i]                   = 1'b1;
            lat_last_d[i*LAT_W +: LAT_W]   = lat_cnt_q;
          end
        end
        if ((lat_cnt_q == LAT_W'(TIMEOUT)) || (arrived_d == launched_q)) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        for (int i = 0; i < LANES; i++) begin
          lat_ok        = (lat_last_q[i*LAT_W +: LAT_W] == LAT_W'(EXP_LAT));
          err_lane_d[i] = err_lane_q[i]
                        | (launched_q[i] ^ arrived_q[i])
                        | (launched_q[i] & arrived_q[i] & ~lat_ok);
        end
        iter_d  = iter_q + 1'b1;
        gap_d   = '0;
        state_d = GAP;
      end

      GAP: begin
        // Any activity here is a stuck or duplicated pulse.
        err_lane_d = err_lane_q | lane_i;
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = (iter_q == ITER_W'(NUM_ITER)) ? DONE : LAUNCH;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      DONE: begin
        if (!run) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LAUNCH) || (state_d == WAIT) ||
             (state_d == CHECK)  || (state_d == GAP);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_lane_d == '0);
  end

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      state_q    <= IDLE;
      start_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_lane_q <= '0;
      lat_last_q <= '0;
      launched_q <= '0;
      arrived_q  <= '0;
      lat_cnt_q  <= '0;
      iter_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_lane_q <= err_lane_d;
      lat_last_q <= lat_last_d;
      launched_q <= launched_d;
      arrived_q  <= arrived_d;
      lat_cnt_q  <= lat_cnt_d;
      iter_q     <= iter_d;
      gap_q      <= gap_d;
    end
  end

  assign start_o  = start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_lane = err_lane_q;
  assign lat_last = lat_last_q;

endmodule

// File: tb/tb_hop_lane_stim_chk.sv
// Bench for hop_lane_stim_chk: lane chains modelled as configurable delay
// lines, outcomes predicted per launch from the LFSR sequence and lane setup.
module tb_hop_lane_stim_chk;

  localparam int         EXP_LAT  = 7;
  localparam int         TIMEOUT  = 31;
  localparam int         GAP_CYC  = 4;
  localparam int         NUM_ITER = 16;
  localparam int         LAT_W    = 5;
  localparam logic [7:0] SEED     = 8'hA5;
  localparam int         LW       = 4 * LAT_W;

  // ---------------- clock / reset ----------------
  logic          clock0 = 1'b0;
  logic          rst1   = 1'b1;
  logic          run    = 1'b0;
  logic [3:0]    lane_i;
  logic [3:0]    start_o;
  logic          busy, done, pass;
  logic [3:0]    err_lane;
  logic [LW-1:0] lat_last;

  always #5 clock0 = ~clock0;

  hop_lane_stim_chk #(
    .EXP_LAT   (EXP_LAT),
    .TIMEOUT   (TIMEOUT),
    .GAP_CYC   (GAP_CYC),
    .NUM_ITER  (NUM_ITER),
    .LAT_W     (LAT_W),
    .LFSR_SEED (SEED)
  ) dut (
    .clock0   (clock0),
    .rst1     (rst1),
    .run      (run),
    .lane_i   (lane_i),
    .start_o  (start_o),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_lane (err_lane),
    .lat_last (lat_last)
  );

  // ---------------- lane chain model ----------------
  int          lane_depth [4] = '{7, 7, 7, 7};
  logic [3:0]  tie_lo = 4'b0;
  logic [3:0]  tie_hi = 4'b0;
  logic [31:0] chain [4];

  always @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      for (int i = 0; i < 4; i++) chain[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) chain[i] <= {chain[i][30:0], start_o[i]};
    end
  end

  always_comb begin
    lane_i = '0;
    for (int i = 0; i < 4; i++) begin
      lane_i[i] = tie_hi[i] ? 1'b1 : (tie_lo[i] ? 1'b0 : chain[i][lane_depth[i]-1]);
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0]    m_lfsr = SEED;
  logic [LW-1:0] m_lat  = '0;
  logic [3:0]    m_err  = '0;

  logic [3:0]    exp_q [$];
  logic [3:0]    exp_err_q [$];
  logic [LW-1:0] exp_lat_q [$];
  int            exp_int_q [$];
  int            exp_done_dist;
  logic [3:0]    exp_fin_err;
  logic [LW-1:0] exp_fin_lat;
  logic          exp_fin_pass;

  // Whole-run prediction: for each launch, when every lane shows up, when
  // WAIT ends, and what that does to the sticky flags and latencies.
  task automatic predict_run();
    logic [3:0] pat;
    logic [3:0] arrived;
    logic       got;
    int         arr [4];
    int         ek;
    m_err = '0;
    for (int n = 0; n < NUM_ITER; n++) begin
      pat    = (m_lfsr[3:0] == 4'h0) ? 4'hF : m_lfsr[3:0];
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      exp_q.push_back(pat);
      exp_err_q.push_back(m_err);
      exp_lat_q.push_back(m_lat);
      for (int i = 0; i < 4; i++) begin
        arr[i] = tie_hi[i] ? 0 : ((tie_lo[i] || !pat[i]) ? -1 : lane_depth[i]);
      end
      ek = TIMEOUT;
      for (int k = 0; k <= TIMEOUT; k++) begin
        for (int i = 0; i < 4; i++) arrived[i] = (arr[i] >= 0) && (arr[i] <= k);
        if (arrived == pat) begin
          ek = k;
          break;
        end
      end
      for (int i = 0; i < 4; i++) begin
        got = (arr[i] >= 0) && (arr[i] <= ek);
        if (got) m_lat[i*LAT_W +: LAT_W] = arr[i][LAT_W-1:0];
        if ((pat[i] != got) || (got && arr[i] != EXP_LAT) || tie_hi[i]) m_err[i] = 1'b1;
      end
      if (n < NUM_ITER - 1) exp_int_q.push_back(ek + 3 + GAP_CYC);
      else                  exp_done_dist = ek + 2 + GAP_CYC;
    end
    exp_fin_err  = m_err;
    exp_fin_lat  = m_lat;
    exp_fin_pass = (m_err == 4'b0);
  endtask

  // ---------------- compare process ----------------
  int         cyc = 0;
  int         last_start = 0;
  int         launch_cnt = 0;
  logic       in_run = 1'b0;
  logic       prev_done = 1'b0;
  logic [3:0] obs_pat [$];

  always @(posedge clock0) cyc <= cyc + 1;

  always @(negedge clock0) begin
    if (rst1) begin
      in_run    = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done && !prev_done) begin
        check("done_err", err_lane, exp_fin_err);
        check("done_pass", pass, exp_fin_pass);
        check("done_lat", lat_last, exp_fin_lat);
        check("done_dist", cyc - last_start, exp_done_dist);
        check("launch_cnt", launch_cnt, NUM_ITER);
        in_run = 1'b0;
      end else if (in_run) begin
        check("busy", busy, 1);
        check("done_low", done, 0);
      end
      if (start_o != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_launch", start_o, 0);
        end else begin
          if (launch_cnt > 0) check("interval", cyc - last_start, exp_int_q.pop_front());
          check("pattern", start_o, exp_q.pop_front());
          check("pre_err", err_lane, exp_err_q.pop_front());
          check("pre_lat", lat_last, exp_lat_q.pop_front());
          check("busy_at_launch", busy, 1);
        end
        obs_pat.push_back(start_o);
        launch_cnt++;
        last_start = cyc;
        in_run     = 1'b1;
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock0);
  endtask

  task automatic set_lanes(input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] lo, input logic [3:0] hi);
    lane_depth = '{d0, d1, d2, d3};
    tie_lo     = lo;
    tie_hi     = hi;
  endtask

  task automatic start_run();
    predict_run();
    launch_cnt = 0;
    obs_pat.delete();
    run = 1'b1;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 3000) begin
      @(negedge clock0);
      t++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic finish_run();
    run = 1'b0;
    tick(3);
    check("done_fall", done, 0);
    check("pass_fall", pass, 0);
    check("err_kept", err_lane, exp_fin_err);
    check("lat_kept", lat_last, exp_fin_lat);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_start"}, start_o, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_lane, 0);
    check({tag, "_lat"}, lat_last, 0);
  endtask

  task automatic check_seed_patterns();
    logic [3:0] lit_pat [6];
    lit_pat = '{4'h5, 4'hA, 4'h5, 4'hA, 4'h4, 4'h9};
    for (int k = 0; k < 6; k++) begin
      check("lit_pattern", (obs_pat.size() > k) ? obs_pat[k] : 4'hx, lit_pat[k]);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [LW-1:0] all_seven;

  initial begin
    all_seven = {4{5'd7}};
    tick(3);
    check_zero_outputs("reset");
    rst1 = 1'b0;
    tick(2);

    // Ideal lanes from reset.
    start_run();
    wait_done();
    check_seed_patterns();
    check("lit_ideal_lat", lat_last, all_seven);
    check("lit_ideal_pass", pass, 1);
    finish_run();

    // Abort during WAIT of the fifth launch, then rerun from the seed.
    start_run();
    for (int t = 0; t < 2000 && launch_cnt < 5; t++) @(negedge clock0);
    check("reached_iter5", launch_cnt, 5);
    tick(3);
    #2 rst1 = 1'b1;
    #1 check_zero_outputs("abort");
    @(negedge clock0);
    run = 1'b0;
    exp_q.delete();
    exp_err_q.delete();
    exp_lat_q.delete();
    exp_int_q.delete();
    m_lfsr = SEED;
    m_lat  = '0;
    tick(2);
    check_zero_outputs("held");
    rst1 = 1'b0;
    tick(2);
    start_run();
    wait_done();
    check_seed_patterns();
    finish_run();

    // Lane 2 one flop short.
    set_lanes(7, 7, 6, 7, 4'b0000, 4'b0000);
    start_run();
    wait_done();
    check("lit_l2_err", err_lane, 4'b0100);
    check("lit_l2_lat", lat_last[2*LAT_W +: LAT_W], 6);
    check("lit_l2_pass", pass, 0);
    finish_run();

    // Lane 0 tied low: launches that include it run to timeout.
    set_lanes(7, 7, 7, 7, 4'b0001, 4'b0000);
    start_run();
    wait_done();
    check("lit_l0_err", err_lane, 4'b0001);
    check("lit_l0_pass", pass, 0);
    finish_run();

    // Lane 3 tied high, then hold run after DONE.
    set_lanes(7, 7, 7, 7, 4'b0000, 4'b1000);
    start_run();
    wait_done();
    check("lit_l3_err", err_lane, 4'b1000);
    check("lit_l3_pass", pass, 0);
    tick(40);
    check("hold_done", done, 1);
    check("hold_no_launch", launch_cnt, NUM_ITER);
    finish_run();

    // Fresh run clears the sticky flags.
    set_lanes(7, 7, 7, 7, 4'b0000, 4'b0000);
    start_run();
    tick(2);
    check("err_cleared", err_lane, 0);
    wait_done();
    check("lit_final_pass", pass, 1);
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
